csa_resolver: RTL and testbench
===============================

CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of each redundant input vector.
REQ-002 The block SHALL have parameter DIGIT, default 2, giving the bits resolved per clock; (WIDTH+2) mod DIGIT SHALL be 0.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, redundant operand pair present.
REQ-006 Port in_ready, output, 1, block can accept an operand pair.
REQ-007 Port in_sum, input, WIDTH, carry-save sum vector, bit i weight 2^i.
REQ-008 Port in_carry, input, WIDTH, carry-save carry vector, bit i weight 2^(i+1).
REQ-009 Port out_valid, output, 1, result holds a resolved value.
REQ-010 Port out_ready, input, 1, downstream accepts the result.
REQ-011 Port result, output, WIDTH+2, binary value in_sum + 2*in_carry.

Function
REQ-012 The block SHALL convert carry-save form to binary with a digit-serial carry-propagate adder, DIGIT bits per cycle, N = (WIDTH+2)/DIGIT cycles.
REQ-013 Internal operands: A = in_sum zero-extended to WIDTH+2; B = {1'b0, in_carry, 1'b0}.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid & in_ready at an edge, A and B are captured, the digit counter and running carry are cleared, and the state becomes RUN.
REQ-016 RUN: in_ready=0; each edge adds digit k of A and B plus the running carry, writes digit k of result, updates the running carry, and increments k.
REQ-017 RUN SHALL go to DONE on the edge that processes digit N-1, so out_valid rises exactly N edges after the accept edge.
REQ-018 DONE: out_valid=1, in_ready=0, and result is held stable until out_valid & out_ready at an edge, which returns the state to IDLE.
REQ-019 With out_ready held low, DONE SHALL persist indefinitely with result unchanged.
REQ-020 Inputs SHALL be sampled only at the accept edge; later changes to in_sum/in_carry SHALL NOT affect result.
REQ-021 in_valid while in RUN or DONE SHALL be ignored and SHALL NOT be lost silently; the upstream must hold it until in_ready.
REQ-022 The carry out of the top digit is always 0 for legal inputs; result SHALL be exact with no truncation.
REQ-023 Throughput SHALL be one result per N+2 cycles when out_ready is held high.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, result=0, digit counter=0, and running carry=0.
REQ-025 Reset asserted in RUN or DONE SHALL discard the in-flight operation; no out_valid pulse SHALL follow release.
REQ-026 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Structure
REQ-027 A shared package csa_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH/DIGIT constants.
REQ-028 The digit adder SHALL be one sub-module, csa_digit_adder: DIGIT-bit ripple of the existing fulladder cell, inputs a, b, cin and outputs s, cout.
REQ-029 Counter width SHALL be clog2(N) bits; the digit select SHALL be by index, not by shifting result.

Verification
REQ-030 in_sum=0xFF, in_carry=0xFF, out_ready=1 -> out_valid 5 edges after accept, result=0x2FD.
REQ-031 in_sum=0x0F, in_carry=0x01 -> result=0x011; in_sum=0x00, in_carry=0x00 -> result=0x000.
REQ-032 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result stable, in_ready stays 0; raise out_ready -> IDLE next edge.
REQ-033 Pull rst_n low on the third RUN cycle -> outputs go to their reset values immediately and no out_valid follows; the next operation (0x80, 0x40) gives 0x100.
REQ-034 Randomised back-to-back stream of 1000 pairs with random out_ready -> every result equals in_sum+2*in_carry, in order, with no drops or duplicates.

Source files
------------

// File: rtl/csa_resolver_pkg.sv
// Shared types and defaults for the carry-save resolver.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 8;
  localparam int unsigned CSA_DIGIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_resolver_if.sv
// Operand/result handshake bundle for csa_resolver.
interface csa_resolver_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] result;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, result
  );

  // Resolver side.
  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/csa_resolver_digit_adder.sv
// DIGIT-bit ripple-carry adder built from single-bit full adders.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module csa_digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    fulladder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c_s[i]),
      .s   (s[i]),
      .cout(c_s[i+1])
    );
  end

  assign cout = c_s[DIGIT];
endmodule

// File: rtl/csa_resolver.sv
// Digit-serial carry-save to binary resolver: one DIGIT-wide slice of
// sum + 2*carry is produced per clock, least significant slice first.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int DIGIT = CSA_DIGIT
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_resolver_if.slave  bus
);
  localparam int RW = WIDTH + 2;
  localparam int N  = RW / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  csa_state_e      state_q, state_d;
  logic [RW-1:0]   a_q, a_d;
  logic [RW-1:0]   b_q, b_d;
  logic [RW-1:0]   result_q, result_d;
  logic [CW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [IW-1:0]    lsb_s;
  logic [DIGIT-1:0] digit_a_s, digit_b_s, digit_sum_s;
  logic             digit_cout_s;

  // Select the active digit of each operand by index.
  always_comb begin
    lsb_s     = IW'(int'(k_q) * DIGIT);
    digit_a_s = a_q[lsb_s +: DIGIT];
    digit_b_s = b_q[lsb_s +: DIGIT];
  end

  csa_digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a   (digit_a_s),
    .b   (digit_b_s),
    .cin (carry_q),
    .s   (digit_sum_s),
    .cout(digit_cout_s)
  );

  // Next-state logic for the accept / run / hold sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    k_d      = k_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d      = {2'b00, bus.in_sum};
          b_d      = {1'b0, bus.in_carry, 1'b0};
          result_d = '0;
          k_d      = '0;
          carry_d  = 1'b0;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[lsb_s +: DIGIT] = digit_sum_s;
        carry_d                  = digit_cout_s;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver (WIDTH=8, DIGIT=2, N=5).
module tb_csa_resolver;
  localparam int W  = 8;
  localparam int RW = W + 2;
  localparam int NSTREAM = 1000;

  typedef struct {
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [RW-1:0] r;
    string         name;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  csa_resolver_if #(.WIDTH(W)) bus ();

  csa_resolver #(.WIDTH(W), .DIGIT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Wait for out_valid after an accept edge; lat counts edges.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 50);
    if (!bus.out_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_pop(input string name);
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_result"}, 32'(bus.result), 32'(exp_q.pop_front()));
    end
  endtask

  // One full transaction with out_ready high; starts and ends at a negedge in IDLE.
  task automatic run_one(input logic [W-1:0] s, input logic [W-1:0] c,
                         input logic [RW-1:0] r, input string name);
    int lat;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_sum   = s;
    bus.in_carry = c;
    bus.in_valid = 1'b1;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sum   = ~s;
    bus.in_carry = ~c;
    wait_valid(name, lat);
    chk({name, "_latency"}, 32'(lat), 32'd5);
    chk({name, "_busy"}, 32'(bus.in_ready), 32'd0);
    chk_pop(name);
    @(posedge clk);
    #1;
    chk({name, "_back_idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    bit seen;
    vecs[0] = '{8'hFF, 8'hFF, 10'h2FD, "ff_ff"};
    vecs[1] = '{8'h0F, 8'h01, 10'h011, "0f_01"};
    vecs[2] = '{8'h00, 8'h00, 10'h000, "zero"};
    vecs[3] = '{8'h80, 8'h40, 10'h100, "80_40"};
    vecs[4] = '{8'h01, 8'h00, 10'h001, "one"};
    vecs[5] = '{8'h00, 8'hFF, 10'h1FE, "carry_only"};
    vecs[6] = '{8'hAA, 8'h55, 10'h154, "aa_55"};
    vecs[7] = '{8'h7F, 8'h80, 10'h17F, "7f_80"};

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; the first accept lands on the first edge after release.
    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].s, vecs[i].c, vecs[i].r, vecs[i].name);
    end

    // Back-pressure with a new request held during DONE.
    bus.out_ready = 1'b0;
    bus.in_sum    = 8'hAA;
    bus.in_carry  = 8'h55;
    bus.in_valid  = 1'b1;
    exp_q.push_back(10'h154);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid("bp", lat);
    chk("bp_latency", 32'(lat), 32'd5);
    chk_pop("bp");
    bus.in_sum   = 8'h12;
    bus.in_carry = 8'h34;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_result", 32'(bus.result), 32'h154);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    exp_q.push_back(10'h07A);
    @(posedge clk);
    #1;
    chk("bp_release_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid("held", lat);
    chk("held_latency", 32'(lat), 32'd5);
    chk_pop("held");
    @(posedge clk);
    @(negedge clk);

    // Reset during the third RUN cycle discards the operation.
    bus.in_sum   = 8'hFF;
    bus.in_carry = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_one(8'h80, 8'h40, 10'h100, "after_rst");

    // Random back-to-back stream with random out_ready.
    fork
      begin : driver
        for (int i = 0; i < NSTREAM; i++) begin
          logic [W-1:0] s;
          logic [W-1:0] c;
          int guard;
          s = 8'($urandom);
          c = 8'($urandom);
          exp_q.push_back({2'b00, s} + {1'b0, c, 1'b0});
          bus.in_sum   = s;
          bus.in_carry = c;
          bus.in_valid = 1'b1;
          guard = 0;
          while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 200) chk("stream_accept_timeout", 32'd0, 32'd1);
          @(posedge clk);
          #1;
          bus.in_valid = 1'b0;
          bus.in_sum   = ~s;
          bus.in_carry = ~c;
          @(negedge clk);
        end
      end
      begin : monitor
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < NSTREAM && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            chk_pop("stream");
            got++;
          end
        end
        chk("stream_count", 32'(got), 32'(NSTREAM));
      end
    join
    repeat (20) @(negedge clk);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
